regfile_sb: RTL and testbench

- Parametrised successor to the single-write, dual-read MIPS32 register file.
- Adds per-register scoreboard busy bits, so decode can detect read-after-write hazards on in-flight producers.
- Adds a synchronous reset and a configurable hardwired-zero register.
- Sits between decode (reads, issue) and writeback (write port) in the pipeline.

---
 rtl/regfile_sb.sv | 98 +++++++++
 tb/tb_regfile_sb.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port, and per-register
// scoreboard busy bits for RAW hazard detection. `WRITE_BYPASS_EN enables write-to-read forwarding.
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] read_addr1,
   input  logic [ADDR_W-1:0] read_addr2,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   output logic              read_busy1,
   output logic              read_busy2,
   output logic              stall,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_addr,
   input  logic              write_enable,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [DATA_W-1:0] write_data,
   output logic [ADDR_W:0]   busy_count
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_next;
   logic [ADDR_W:0]   busy_count_next;
   logic              write_ok;
   logic              issue_ok;

   logic [ADDR_W-1:0] ra [2];
   logic [DATA_W-1:0] rd [2];
   logic              rb [2];

   // Register 0, when hardwired, swallows both writes and issues.
   assign write_ok = write_enable && !((ZERO_REG != 0) && (write_addr == '0));
   assign issue_ok = issue_valid  && !((ZERO_REG != 0) && (issue_addr == '0));

   // Clear first, then set: a same-address issue outranks the writeback.
   always_comb begin
      busy_next = busy;
      if (write_ok) busy_next[write_addr] = 1'b0;
      if (issue_ok) busy_next[issue_addr] = 1'b1;
   end

   always_comb begin
      busy_count_next = '0;
      for (int i = 0; i < DEPTH; i++) begin
         busy_count_next = busy_count_next + (ADDR_W+1)'(busy_next[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         busy       <= '0;
         busy_count <= '0;
      end else begin
         if (write_ok) regs[write_addr] <= write_data;
         busy       <= busy_next;
         busy_count <= busy_count_next;
      end
   end

   assign ra[0] = read_addr1;
   assign ra[1] = read_addr2;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd[p] = regs[ra[p]];
         rb[p] = busy[ra[p]];
`ifdef WRITE_BYPASS_EN
         if (write_enable && (ra[p] == write_addr)) begin
            rd[p] = write_data;
            rb[p] = issue_valid && (issue_addr == ra[p]);
         end
`endif
         if ((ZERO_REG != 0) && (ra[p] == '0)) begin
            rd[p] = '0;
            rb[p] = 1'b0;
         end
      end
   end

   assign read_data1 = rd[0];
   assign read_data2 = rd[1];
   assign read_busy1 = rb[0];
   assign read_busy2 = rb[1];

   // Held low while reset is asserted so decode never sees a stale hazard.
   assign stall = rst_n && (rb[0] || rb[1]);

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and randomized checks of regfile_sb against an array-based reference model.
module tb_regfile_sb;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int ZERO_REG = 1;
   localparam int DEPTH    = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [ADDR_W-1:0] read_addr1, read_addr2;
   logic [DATA_W-1:0] read_data1, read_data2;
   logic              read_busy1, read_busy2, stall;
   logic              issue_valid;
   logic [ADDR_W-1:0] issue_addr;
   logic              write_enable;
   logic [ADDR_W-1:0] write_addr;
   logic [DATA_W-1:0] write_data;
   logic [ADDR_W:0]   busy_count;

   int vectors = 0;
   int errors  = 0;

   logic [DATA_W-1:0] m_regs [DEPTH];
   bit                m_busy [DEPTH];

   regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) dut (
      .clk(clk), .rst_n(rst_n),
      .read_addr1(read_addr1), .read_addr2(read_addr2),
      .read_data1(read_data1), .read_data2(read_data2),
      .read_busy1(read_busy1), .read_busy2(read_busy2), .stall(stall),
      .issue_valid(issue_valid), .issue_addr(issue_addr),
      .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
      .busy_count(busy_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_zero(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == 0);
   endfunction

   function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a);
      if (is_zero(a)) return '0;
`ifdef WRITE_BYPASS_EN
      if (write_enable && write_addr == a) return write_data;
`endif
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(input logic [ADDR_W-1:0] a);
      if (is_zero(a)) return 1'b0;
`ifdef WRITE_BYPASS_EN
      if (write_enable && write_addr == a) return issue_valid && issue_addr == a;
`endif
      return m_busy[a];
   endfunction

   function automatic int m_count();
      int n = 0;
      for (int i = 0; i < DEPTH; i++) n += int'(m_busy[i]);
      return n;
   endfunction

   task automatic model_clock();
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
         end
      end else begin
         if (write_enable && !is_zero(write_addr)) begin
            m_regs[write_addr] = write_data;
            m_busy[write_addr] = 1'b0;
         end
         if (issue_valid && !is_zero(issue_addr)) m_busy[issue_addr] = 1'b1;
      end
   endtask

   // Check all outputs for the current inputs, then clock DUT and model together.
   task automatic tick();
      logic e1, e2;
      e1 = exp_busy(read_addr1);
      e2 = exp_busy(read_addr2);
      check("read_data1", 64'(read_data1), 64'(exp_data(read_addr1)));
      check("read_data2", 64'(read_data2), 64'(exp_data(read_addr2)));
      check("read_busy1", 64'(read_busy1), 64'(e1));
      check("read_busy2", 64'(read_busy2), 64'(e2));
      check("stall", 64'(stall), 64'(rst_n && (e1 || e2)));
      check("busy_count", 64'(busy_count), 64'(m_count()));
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic drive(input logic [ADDR_W-1:0] ra1, input logic [ADDR_W-1:0] ra2,
                        input logic iv, input logic [ADDR_W-1:0] ia,
                        input logic we, input logic [ADDR_W-1:0] wa,
                        input logic [DATA_W-1:0] wd);
      read_addr1 = ra1; read_addr2 = ra2;
      issue_valid = iv; issue_addr = ia;
      write_enable = we; write_addr = wa; write_data = wd;
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      @(posedge clk);
      model_clock();
      #1;
      rst_n = 1'b1;
      tick();

      // Reset clears a written register
      drive(0, 0, 0, 0, 1, 5, 32'hDEADBEEF);
      tick();
      rst_n = 1'b0;
      drive(5, 5, 0, 0, 0, 0, 0);
      tick();
      rst_n = 1'b1;
      drive(5, 5, 0, 0, 0, 0, 0);
      check("reset_r5", 64'(read_data1), 64'h0);
      check("reset_count", 64'(busy_count), 64'h0);
      check("reset_stall", 64'(stall), 64'h0);
      tick();

      // Basic write/read and hardwired zero
      drive(0, 0, 0, 0, 1, 7, 32'h9);
      tick();
      drive(7, 0, 0, 0, 1, 0, 32'h12345678);
      check("r7_read", 64'(read_data1), 64'h9);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      check("r0_zero", 64'(read_data1), 64'h0);
      tick();

      // Scoreboard set and clear
      drive(0, 3, 1, 3, 0, 0, 0);
      tick();
      drive(0, 3, 0, 0, 0, 0, 0);
      check("r3_busy", 64'(read_busy2), 64'h1);
      check("r3_stall", 64'(stall), 64'h1);
      check("r3_count", 64'(busy_count), 64'h1);
      drive(0, 3, 0, 0, 1, 3, 32'h50);
      tick();
      drive(0, 3, 0, 0, 0, 0, 0);
      check("r3_clear", 64'(read_busy2), 64'h0);
      check("r3_nostall", 64'(stall), 64'h0);
      check("r3_data", 64'(read_data2), 64'h50);
      check("r3_count0", 64'(busy_count), 64'h0);
      tick();

      // Same-cycle issue and write to r4
      drive(0, 0, 1, 4, 0, 0, 0);
      tick();
      drive(0, 0, 1, 4, 1, 4, 32'h40);
      tick();
      drive(4, 0, 0, 0, 0, 0, 0);
      check("r4_data", 64'(read_data1), 64'h40);
      check("r4_busy", 64'(read_busy1), 64'h1);
      check("r4_count", 64'(busy_count), 64'h1);
      drive(0, 0, 0, 0, 1, 4, 32'h41);
      tick();

      // Write bypass behaviour on r8
      drive(8, 0, 0, 0, 1, 8, 32'h1);
`ifdef WRITE_BYPASS_EN
      check("bypass_data", 64'(read_data1), 64'h1);
      check("bypass_busy", 64'(read_busy1), 64'h0);
`else
      check("nobypass_old", 64'(read_data1), 64'h0);
`endif
      tick();
      drive(8, 0, 0, 0, 0, 0, 0);
      check("r8_next", 64'(read_data1), 64'h1);
      tick();

      // Reset mid-operation discards producers
      drive(0, 0, 1, 1, 0, 0, 0); tick();
      drive(0, 0, 1, 2, 0, 0, 0); tick();
      drive(0, 0, 1, 6, 0, 0, 0); tick();
      drive(1, 2, 0, 0, 0, 0, 0);
      check("mid_count3", 64'(busy_count), 64'h3);
      rst_n = 1'b0;
      drive(1, 2, 0, 0, 1, 2, 32'hAA);
      tick();
      rst_n = 1'b1;
      drive(6, 2, 0, 0, 0, 0, 0);
      check("mid_count0", 64'(busy_count), 64'h0);
      check("mid_r2", 64'(read_data2), 64'h0);
      check("mid_busy2", 64'(read_busy2), 64'h0);
      check("mid_busy6", 64'(read_busy1), 64'h0);
      tick();

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         rst_n = ($urandom_range(0, 79) != 0);
         drive(ADDR_W'($urandom_range(0, DEPTH-1)), ADDR_W'($urandom_range(0, DEPTH-1)),
               1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, DEPTH-1)),
               1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, DEPTH-1)),
               DATA_W'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            write_addr = read_addr1;
            #1;
         end
         tick();
      end
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
